// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared types for the multicycle RV32I control FSM.
// Optional ECALL/EBREAK halt state is enabled by RISCV_MC_HALT_EN.
package riscv_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI,
        S_ERROR, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
    } imm_src_e;

    typedef enum logic [1:0] {
        CAUSE_NONE, CAUSE_TIMEOUT, CAUSE_ILLEGAL
    } error_cause_e;

    typedef enum logic [1:0] {
        ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_R, ALU_CLS_I
    } alu_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic imm_src_e imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Unified memory port handshake between the control FSM and memory.
interface riscv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/riscv_multicycle_ctrl_alu_dec.sv
// ALU operation decoder: instruction class plus funct fields to alu_op_e.
import riscv_multicycle_ctrl_pkg::*;

module riscv_alu_decoder (
    input  alu_class_e  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output alu_op_e     alu_ctrl
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_class)
            ALU_CLS_ADD: alu_ctrl = ALU_ADD;
            ALU_CLS_SUB: alu_ctrl = ALU_SUB;
            default: begin
                // SLTU and SRA map onto the nearest supported op
                unique case (funct3)
                    3'b000: alu_ctrl = (alu_class == ALU_CLS_R && funct7b5)
                                       ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLT;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I main control FSM with memory timeout and retire counter.
// Define RISCV_MC_HALT_EN to halt on ECALL/EBREAK instead of faulting.
import riscv_multicycle_ctrl_pkg::*;

module riscv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              zero,
    riscv_multicycle_ctrl_if.master mem,
    output logic              adr_src,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_ctrl,
    output logic [1:0]        result_src,
    output logic [2:0]        imm_src,
    output logic              error,
    output logic [1:0]        error_cause,
    output logic [CNT_W-1:0]  instret
);
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'(TMO_EN ? MEM_TIMEOUT - 1 : 0);

    state_e       state, state_n;
    error_cause_e cause_q, cause_n;
    logic [TMO_W-1:0] wait_cnt;
    logic         retire, req, we, timeout;
    alu_class_e   alu_cls;
    alu_op_e      alu_op;

    riscv_alu_decoder u_alu_dec (
        .alu_class (alu_cls),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .alu_ctrl  (alu_op)
    );

    assign timeout = TMO_EN && req && !mem.mem_ready && wait_cnt == TMO_LAST;

    always_comb begin
        state_n    = state;
        cause_n    = cause_q;
        retire     = 1'b0;
        req        = 1'b0;
        we         = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_cls    = ALU_CLS_ADD;
        result_src = 2'd0;
        case (state)
            S_FETCH: begin
                req        = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:      state_n = S_EXEC_R;
                    OP_I:      state_n = S_EXEC_I;
                    OP_BRANCH: state_n = S_BRANCH;
                    OP_JAL:    state_n = S_JAL;
                    OP_JALR:   state_n = S_JALR;
                    OP_LUI:    state_n = S_LUI;
`ifdef RISCV_MC_HALT_EN
                    OP_SYSTEM: begin
                        state_n = S_HALT;
                        retire  = 1'b1;
                    end
`endif
                    default: begin
                        state_n = S_ERROR;
                        cause_n = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                state_n   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req     = 1'b1;
                adr_src = 1'b1;
                if (mem.mem_ready) state_n = S_MEMWB;
            end
            S_MEMWRITE: begin
                req     = 1'b1;
                we      = 1'b1;
                adr_src = 1'b1;
                if (mem.mem_ready) begin
                    state_n = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                state_n    = S_FETCH;
                retire     = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_cls   = ALU_CLS_R;
                state_n   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_cls   = ALU_CLS_I;
                state_n   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_cls   = ALU_CLS_SUB;
                pc_write  = zero ^ funct3[0];
                state_n   = S_FETCH;
                retire    = 1'b1;
            end
            S_JAL: begin
                // ALU forms the link address while ALUOut holds the target
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                state_n   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                state_n   = S_JAL;
            end
            S_LUI: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd1;
                state_n   = S_ALUWB;
            end
            default: ;
        endcase
        if (timeout) begin
            state_n = S_ERROR;
            cause_n = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state   <= state_n;
            cause_q <= cause_n;
            if (retire) instret <= instret + CNT_W'(1);
            if (state_n != state) wait_cnt <= '0;
            else if (req && !mem.mem_ready) wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

    assign mem.mem_req  = req & ~reset;
    assign mem.mem_we   = we & ~reset;
    assign alu_ctrl     = alu_op;
    assign imm_src      = imm_sel(op);
    assign error        = (state == S_ERROR);
    assign error_cause  = cause_q;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized bench for riscv_multicycle_ctrl against a phase-table model.
// Honours RISCV_MC_HALT_EN for the ECALL scenario.
module tb_riscv_multicycle_ctrl;
    import riscv_multicycle_ctrl_pkg::*;

    localparam int TMO = 4;
    localparam int CW  = 32;

    typedef enum int {
        PF, PD, PA, PRD, PMW, PWR, PXR, PXI, PWB, PBR, PJ, PJR, PLUI, PERR, PH
    } ph_t;
    typedef enum int {
        C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI, C_SYS, C_ILL
    } cls_t;
    typedef struct {
        cls_t       c;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
    } ins_t;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic funct7b5, zero;
    logic adr_src, ir_write, pc_write, reg_write, error;
    logic [1:0] alu_src_a, alu_src_b, result_src, error_cause;
    logic [2:0] alu_ctrl, imm_src;
    logic [CW-1:0] instret;

    riscv_multicycle_ctrl_if mem ();

    riscv_multicycle_ctrl #(
        .MEM_TIMEOUT (TMO),
        .TMO_W       (8),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem         (mem),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_ctrl    (alu_ctrl),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .error       (error),
        .error_cause (error_cause),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ph_t  mph;
    int   idx, wcnt;
    cls_t cur_cls;
    logic [31:0] m_instret;
    logic [1:0]  m_cause;
    ins_t prog[$];
    logic last_req, last_adr, last_rw, last_pcw, last_irw;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic ph_t path(input cls_t c, input int i);
        ph_t p[6];
        case (c)
            C_R:    p = '{PF, PD, PXR, PWB, PF, PF};
            C_I:    p = '{PF, PD, PXI, PWB, PF, PF};
            C_LW:   p = '{PF, PD, PA, PRD, PMW, PF};
            C_SW:   p = '{PF, PD, PA, PWR, PF, PF};
            C_BR:   p = '{PF, PD, PBR, PF, PF, PF};
            C_JAL:  p = '{PF, PD, PJ, PWB, PF, PF};
            C_JALR: p = '{PF, PD, PJR, PJ, PWB, PF};
            C_LUI:  p = '{PF, PD, PLUI, PWB, PF, PF};
`ifdef RISCV_MC_HALT_EN
            C_SYS:  p = '{PF, PD, PH, PH, PH, PH};
`endif
            default: p = '{PF, PD, PERR, PERR, PERR, PERR};
        endcase
        return p[i];
    endfunction

    function automatic logic [2:0] alu_exp(input logic [2:0] f3,
                                           input logic f7, input bit is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLT;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] imm_exp(input logic [6:0] o);
        case (o)
            7'b0100011: return IMM_S;
            7'b1100011: return IMM_B;
            7'b1101111: return IMM_J;
            7'b0110111: return IMM_U;
            default:    return IMM_I;
        endcase
    endfunction

    function automatic ins_t mk(input cls_t c, input logic [2:0] f3,
                                input logic f7);
        ins_t r;
        logic [6:0] ill[4];
        ill = '{7'b0000000, 7'b1111111, 7'b0010111, 7'b0001111};
        r.c = c; r.f3 = f3; r.f7 = f7;
        case (c)
            C_R:    r.op = 7'b0110011;
            C_I:    r.op = 7'b0010011;
            C_LW:   r.op = 7'b0000011;
            C_SW:   r.op = 7'b0100011;
            C_BR:   r.op = 7'b1100011;
            C_JAL:  r.op = 7'b1101111;
            C_JALR: r.op = 7'b1100111;
            C_LUI:  r.op = 7'b0110111;
            C_SYS:  r.op = 7'b1110011;
            default: r.op = ill[$urandom_range(0, 3)];
        endcase
        return r;
    endfunction

    function automatic cls_t rand_cls();
        case ($urandom_range(0, 15))
            0, 1, 15: return C_R;
            2, 3:     return C_I;
            4, 5:     return C_LW;
            6, 7:     return C_SW;
            8, 9:     return C_BR;
            10:       return C_JAL;
            11:       return C_JALR;
            12:       return C_LUI;
            13:       return C_SYS;
            default:  return C_ILL;
        endcase
    endfunction

    task automatic load_instr();
        ins_t n;
        if (prog.size() != 0) n = prog.pop_front();
        else n = mk(rand_cls(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        cur_cls = n.c; op = n.op; funct3 = n.f3; funct7b5 = n.f7;
    endtask

    // One clock: drive at negedge, compare, then advance the model
    task automatic step(input logic rdy, input logic z);
        logic e_req, e_we, e_adr, e_irw, e_pcw, e_rw;
        logic [1:0] e_sa, e_sb, e_rs;
        logic [2:0] e_alu;
        ph_t nph;
        mem.mem_ready = rdy;
        zero = z;
        #1;
        {e_req, e_we, e_adr, e_irw, e_pcw, e_rw} = '0;
        e_sa = 0; e_sb = 0; e_rs = 0; e_alu = ALU_ADD;
        case (mph)
            PF:   begin e_req = 1; e_sb = 2; e_rs = 2; e_irw = rdy; e_pcw = rdy; end
            PD:   begin e_sa = 1; e_sb = 1; end
            PA:   begin e_sa = 2; e_sb = 1; end
            PRD:  begin e_req = 1; e_adr = 1; end
            PWR:  begin e_req = 1; e_we = 1; e_adr = 1; end
            PMW:  begin e_rs = 1; e_rw = 1; end
            PXR:  begin e_sa = 2; e_alu = alu_exp(funct3, funct7b5, 1); end
            PXI:  begin e_sa = 2; e_sb = 1; e_alu = alu_exp(funct3, funct7b5, 0); end
            PWB:  e_rw = 1;
            PBR:  begin e_sa = 2; e_alu = ALU_SUB; e_pcw = z ^ funct3[0]; end
            PJ:   begin e_sa = 1; e_sb = 2; e_pcw = 1; end
            PJR:  begin e_sa = 2; e_sb = 1; end
            PLUI: begin e_sa = 3; e_sb = 1; end
            default: ;
        endcase
        chk("mem_req", mem.mem_req, e_req);
        chk("mem_we", mem.mem_we, e_we);
        chk("adr_src", adr_src, e_adr);
        chk("ir_write", ir_write, e_irw);
        chk("pc_write", pc_write, e_pcw);
        chk("reg_write", reg_write, e_rw);
        chk("alu_src_a", alu_src_a, e_sa);
        chk("alu_src_b", alu_src_b, e_sb);
        chk("alu_ctrl", alu_ctrl, e_alu);
        chk("result_src", result_src, e_rs);
        chk("imm_src", imm_src, imm_exp(op));
        chk("error", error, mph == PERR);
        chk("error_cause", error_cause, m_cause);
        chk("instret", instret, m_instret);
        last_req = mem.mem_req; last_adr = adr_src; last_rw = reg_write;
        last_pcw = pc_write; last_irw = ir_write;
        if (mph == PERR || mph == PH) begin
        end else if ((mph == PF || mph == PRD || mph == PWR) && !rdy) begin
            if (wcnt == TMO - 1) begin
                mph = PERR; m_cause = 2'd1; wcnt = 0;
            end else wcnt++;
        end else begin
            wcnt = 0;
            if (mph == PF) begin
                load_instr();
                idx = 1; mph = PD;
            end else begin
                nph = path(cur_cls, idx + 1);
                idx++;
                if (nph == PF) begin m_instret++; idx = 0; end
                if (nph == PH) m_instret++;
                if (nph == PERR) m_cause = 2'd2;
                mph = nph;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem.mem_ready = 1'b0;
        #1;
        chk("rst_req", mem.mem_req, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_instret", instret, 0);
        chk("rst_error", error, 0);
        chk("rst_cause", error_cause, 0);
        reset = 1'b0;
        mph = PF; idx = 0; wcnt = 0; m_instret = 0; m_cause = 0;
    endtask

    initial begin
        logic [3:0] rw_hist;
        int nreq;
        logic anyen;
        ins_t t;
        reset = 1'b1; op = 0; funct3 = 0; funct7b5 = 0; zero = 0;
        mem.mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        prog.push_back(mk(C_R, 3'd0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            rw_hist[i] = last_rw;
        end
        chk("add_rw_cycles", 32'(rw_hist), 32'b1000);
        chk("add_instret", instret, 1);

        prog.push_back(mk(C_LW, 3'd2, 1'b0));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, 1'b0);
            nreq += int'(last_req & last_adr);
        end
        chk("lw_req_cycles", nreq, 4);
        step(1'b1, 1'b0);
        chk("lw_instret", instret, 2);

        prog.push_back(mk(C_BR, 3'd0, 1'b0));
        prog.push_back(mk(C_BR, 3'd1, 1'b0));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("beq_pc_write", last_pcw, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("bne_pc_write", last_pcw, 0);
        chk("br_instret", instret, 4);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("tmo_error", error, 1);
        chk("tmo_cause", error_cause, 1);
        anyen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            anyen |= last_req | last_pcw | last_rw | last_irw;
        end
        chk("err_quiet", anyen, 0);
        chk("err_instret_frozen", instret, 4);

        do_reset();
        t = mk(C_ILL, 3'd0, 1'b0);
        t.op = 7'b0000000;
        prog.push_back(t);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("ill_cause", error_cause, 2);
        do_reset();
        chk("ill_rst_error", error, 0);

        prog.push_back(mk(C_R, 3'd0, 1'b0));
        prog.push_back(mk(C_I, 3'd0, 1'b0));
        prog.push_back(mk(C_SYS, 3'd0, 1'b0));
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
`ifdef RISCV_MC_HALT_EN
        chk("halt_instret", instret, 3);
        chk("halt_req", last_req, 0);
        chk("halt_error", error, 0);
`else
        chk("ecall_cause", error_cause, 2);
        chk("ecall_instret", instret, 2);
`endif

        do_reset();
        prog.push_back(mk(C_LW, 3'd2, 1'b0));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        mem.mem_ready = 1'b0;
        #1;
        chk("rd_req_before", mem.mem_req, 1);
        reset = 1'b1;
        #1;
        chk("async_req_drop", mem.mem_req, 0);
        do_reset();

        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++)
                step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
